dfi_cmd_sched: RTL and testbench
================================

DFI_CMD_SCHED -- requirements
Module: dfi_cmd_sched

Interface
REQ-001 Parameters SHALL be: NUM_BANKS, default 8, number of bank requesters; BA_WIDTH, default 3, DFI bank width; ADDR_WIDTH, default 14, DFI address width; CS_WIDTH, default 1, chip-select width; T_WIDTH, default 4, timing field width; ODT_CYCLES, default 4, ODT hold after WR.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 act_req, rd_req, wr_req, pre_req  input  NUM_BANKS each  per-bank command request; bit i belongs to bank i.
REQ-005 ref_req  input  1  all-bank refresh request from the refresh controller.
REQ-006 bk_addr  input  NUM_BANKS*ADDR_WIDTH  per-bank row (ACT) or column (RD/WR) address; slice i belongs to bank i.
REQ-007 act_gnt, rd_gnt, wr_gnt, pre_gnt  output  NUM_BANKS each  per-bank grant, combinational, same cycle as request.
REQ-008 ref_gnt  output  1  refresh grant, combinational.
REQ-009 t_rrd, t_ccd, t_wtr, t_rtw  input  T_WIDTH each  quasi-static spacing, in cycles.
REQ-010 dfi_cke  output  1; dfi_cs_n  output  CS_WIDTH; dfi_ras_n, dfi_cas_n, dfi_we_n  output  1 each; dfi_ba  output  BA_WIDTH; dfi_addr  output  ADDR_WIDTH; dfi_odt  output  1. All registered.

Function
REQ-011 At most one grant (across all grant outputs) SHALL be asserted per cycle.
REQ-012 Grants SHALL be asserted only when the matching request is high; rst high forces all grants to 0.
REQ-013 Class priority SHALL be REF > CAS (RD/WR) > ACT > PRE.
REQ-014 REF SHALL be granted only when ref_req is high and no spacing counter is nonzero.
REQ-015 Within CAS, ACT and PRE classes, selection SHALL be round-robin over eligible banks, one pointer per class, starting at the pointer index and searching upward modulo NUM_BANKS.
REQ-016 On a grant in a class, that class pointer SHALL become (winner+1) mod NUM_BANKS; other pointers unchanged.
REQ-017 A bank asserting both rd_req and wr_req in one cycle is illegal; the bench SHALL flag it with an assertion.
REQ-018 Spacing counters rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt SHALL each load (t-1) on the issuing command (rrd: ACT; ccd: RD or WR; wtr: WR; rtw: RD), saturate-decrement to 0 otherwise, and treat t=0 as t=1.
REQ-019 ACT SHALL be eligible only when rrd_cnt==0; RD only when ccd_cnt==0 and wtr_cnt==0; WR only when ccd_cnt==0 and rtw_cnt==0; PRE always.
REQ-020 A command granted in cycle c SHALL appear on DFI outputs in cycle c+1 (one-cycle latency).
REQ-021 Encodings (ras_n,cas_n,we_n): ACT 011, RD 101, WR 100, PRE 010, REF 001, NOP 111; dfi_cs_n all 0 on command, all 1 when no command.
REQ-022 dfi_ba SHALL be the winning bank index (truncated/zero-extended to BA_WIDTH); dfi_addr SHALL be that bank's bk_addr slice; PRE SHALL drive dfi_addr all 0 (A10=0, single bank); REF SHALL drive dfi_ba=0, dfi_addr=0.
REQ-023 With no grant, dfi_ba and dfi_addr SHALL hold their previous values.
REQ-024 dfi_odt SHALL go high with the WR command cycle and stay high for ODT_CYCLES cycles; a new WR during that window restarts the count.
REQ-025 dfi_cke SHALL be 1 from the first cycle after rst deasserts.
REQ-026 Counters SHALL reload when a new issuing command arrives with nonzero count (reload wins over decrement).

Reset
REQ-027 While rst is high: dfi_cke=0, dfi_cs_n all 1, dfi_ras_n=dfi_cas_n=dfi_we_n=1, dfi_ba=0, dfi_addr=0, dfi_odt=0, all counters 0, all RR pointers 0, all grants 0.
REQ-028 rst asserted mid-operation SHALL abort pending spacing and ODT windows immediately; no command issues during or on the cycle rst is sampled high.

Verification
REQ-029 Bench SHALL cover: act_req=8'hFF, t_rrd=4 -> act_gnt one-hot banks 0,1,2,... at cycles 0,4,8,...; DFI ACT one cycle later each.
REQ-030 Bench SHALL cover: WR bank 2 then rd_req bank 2, t_wtr=5, t_ccd=2 -> rd_gnt 5 cycles after wr_gnt; dfi_odt high 4 cycles from WR.
REQ-031 Bench SHALL cover: ref_req with act_req bank 0 in same cycle, counters 0 -> ref_gnt=1, act_gnt=0; DFI 0,0,1 with ba=0, addr=0.
REQ-032 Bench SHALL cover: rd_req and pre_req on different banks simultaneously -> rd_gnt first, pre_gnt next cycle.
REQ-033 Bench SHALL cover: rst pulsed while rtw_cnt=3 and odt active -> all outputs at reset values next cycle; WR granted first cycle after release.
REQ-034 Bench SHALL cover: t_ccd=0 and t_ccd=1 -> back-to-back RD grants every cycle.

Source files
------------

// File: rtl/dfi_cmd_sched.sv
// DFI command scheduler: arbitrates per-bank ACT/RD/WR/PRE requests and a refresh
// request into one DFI command per cycle, enforcing tRRD/tCCD/tWTR/tRTW spacing.
module dfi_cmd_sched #(
  parameter int NUM_BANKS  = 8,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int CS_WIDTH   = 1,
  parameter int T_WIDTH    = 4,
  parameter int ODT_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANKS-1:0]          act_req,
  input  logic [NUM_BANKS-1:0]          rd_req,
  input  logic [NUM_BANKS-1:0]          wr_req,
  input  logic [NUM_BANKS-1:0]          pre_req,
  input  logic                          ref_req,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] bk_addr,
  output logic [NUM_BANKS-1:0]          act_gnt,
  output logic [NUM_BANKS-1:0]          rd_gnt,
  output logic [NUM_BANKS-1:0]          wr_gnt,
  output logic [NUM_BANKS-1:0]          pre_gnt,
  output logic                          ref_gnt,
  input  logic [T_WIDTH-1:0]            t_rrd,
  input  logic [T_WIDTH-1:0]            t_ccd,
  input  logic [T_WIDTH-1:0]            t_wtr,
  input  logic [T_WIDTH-1:0]            t_rtw,
  output logic                          dfi_cke,
  output logic [CS_WIDTH-1:0]           dfi_cs_n,
  output logic                          dfi_ras_n,
  output logic                          dfi_cas_n,
  output logic                          dfi_we_n,
  output logic [BA_WIDTH-1:0]           dfi_ba,
  output logic [ADDR_WIDTH-1:0]         dfi_addr,
  output logic                          dfi_odt
);

  localparam int PTR_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ODT_W    = (ODT_CYCLES > 1) ? $clog2(ODT_CYCLES + 1) : 1;
  localparam int ODT_LOAD = (ODT_CYCLES > 0) ? ODT_CYCLES - 1 : 0;
  localparam bit ODT_ON   = (ODT_CYCLES > 0);

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF
  } cmd_e;

  // Round-robin search: result MSB is "found", low bits the first eligible bank
  // at or above ptr, wrapping modulo NUM_BANKS.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_BANKS-1:0] elig,
                                             input logic [PTR_W-1:0]     ptr);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_BANKS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_BANKS;
      if (elig[idx]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return PTR_W'((int'(p) + 1) % NUM_BANKS);
  endfunction

  // A spacing of 0 behaves like 1: the next command may follow immediately.
  function automatic logic [T_WIDTH-1:0] t_load(input logic [T_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [T_WIDTH-1:0] sat_dec(input logic [T_WIDTH-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  function automatic logic [2:0] cmd_bits(input cmd_e c);
    case (c)
      CMD_ACT: return 3'b011;
      CMD_RD:  return 3'b101;
      CMD_WR:  return 3'b100;
      CMD_PRE: return 3'b010;
      CMD_REF: return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  logic [T_WIDTH-1:0]    rrd_cnt_q, ccd_cnt_q, wtr_cnt_q, rtw_cnt_q;
  logic [T_WIDTH-1:0]    rrd_cnt_d, ccd_cnt_d, wtr_cnt_d, rtw_cnt_d;
  logic [PTR_W-1:0]      cas_ptr_q, act_ptr_q, pre_ptr_q;
  logic [ODT_W-1:0]      odt_cnt_q;
  logic                  odt_q, cke_q;
  logic [CS_WIDTH-1:0]   cs_n_q;
  logic [2:0]            cmd_q;
  logic [BA_WIDTH-1:0]   ba_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  rd_ok, wr_ok, act_ok, cnt_idle;
  logic [NUM_BANKS-1:0]  cas_elig, act_elig;
  logic [PTR_W:0]        cas_pick, act_pick, pre_pick;
  cmd_e                  cmd;
  logic [PTR_W-1:0]      win;
  logic [BA_WIDTH-1:0]   win_ba;
  logic [ADDR_WIDTH-1:0] win_addr;

  assign rd_ok    = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
  assign wr_ok    = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);
  assign act_ok   = (rrd_cnt_q == '0);
  assign cnt_idle = act_ok && rd_ok && (rtw_cnt_q == '0);

  assign cas_elig = (rd_req & {NUM_BANKS{rd_ok}}) | (wr_req & {NUM_BANKS{wr_ok}});
  assign act_elig = act_req & {NUM_BANKS{act_ok}};
  assign cas_pick = rr_pick(cas_elig, cas_ptr_q);
  assign act_pick = rr_pick(act_elig, act_ptr_q);
  assign pre_pick = rr_pick(pre_req, pre_ptr_q);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // grant unassigned and no latch is inferred.
  always_comb begin
    cmd     = CMD_NOP;
    win     = '0;
    act_gnt = '0;
    rd_gnt  = '0;
    wr_gnt  = '0;
    pre_gnt = '0;
    ref_gnt = 1'b0;
    if (!rst) begin
      if (ref_req && cnt_idle) begin
        cmd     = CMD_REF;
        ref_gnt = 1'b1;
      end else if (cas_pick[PTR_W]) begin
        win = cas_pick[PTR_W-1:0];
        if (rd_req[win] && rd_ok) begin
          cmd         = CMD_RD;
          rd_gnt[win] = 1'b1;
        end else begin
          cmd         = CMD_WR;
          wr_gnt[win] = 1'b1;
        end
      end else if (act_pick[PTR_W]) begin
        win          = act_pick[PTR_W-1:0];
        cmd          = CMD_ACT;
        act_gnt[win] = 1'b1;
      end else if (pre_pick[PTR_W]) begin
        win          = pre_pick[PTR_W-1:0];
        cmd          = CMD_PRE;
        pre_gnt[win] = 1'b1;
      end
    end
  end

  assign win_ba   = BA_WIDTH'(win);
  assign win_addr = bk_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];

  // A reload on the issuing command takes precedence over the decrement.
  assign rrd_cnt_d = (cmd == CMD_ACT) ? t_load(t_rrd) : sat_dec(rrd_cnt_q);
  assign ccd_cnt_d = (cmd == CMD_RD || cmd == CMD_WR) ? t_load(t_ccd) : sat_dec(ccd_cnt_q);
  assign wtr_cnt_d = (cmd == CMD_WR) ? t_load(t_wtr) : sat_dec(wtr_cnt_q);
  assign rtw_cnt_d = (cmd == CMD_RD) ? t_load(t_rtw) : sat_dec(rtw_cnt_q);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cke_q     <= 1'b0;
      cs_n_q    <= '1;
      cmd_q     <= 3'b111;
      ba_q      <= '0;
      addr_q    <= '0;
      odt_q     <= 1'b0;
      odt_cnt_q <= '0;
      rrd_cnt_q <= '0;
      ccd_cnt_q <= '0;
      wtr_cnt_q <= '0;
      rtw_cnt_q <= '0;
      cas_ptr_q <= '0;
      act_ptr_q <= '0;
      pre_ptr_q <= '0;
    end else begin
      cke_q     <= 1'b1;
      cs_n_q    <= (cmd == CMD_NOP) ? '1 : '0;
      cmd_q     <= cmd_bits(cmd);
      rrd_cnt_q <= rrd_cnt_d;
      ccd_cnt_q <= ccd_cnt_d;
      wtr_cnt_q <= wtr_cnt_d;
      rtw_cnt_q <= rtw_cnt_d;

      case (cmd)
        CMD_ACT: begin
          ba_q      <= win_ba;
          addr_q    <= win_addr;
          act_ptr_q <= ptr_inc(win);
        end
        CMD_RD, CMD_WR: begin
          ba_q      <= win_ba;
          addr_q    <= win_addr;
          cas_ptr_q <= ptr_inc(win);
        end
        CMD_PRE: begin
          ba_q      <= win_ba;
          addr_q    <= '0;
          pre_ptr_q <= ptr_inc(win);
        end
        CMD_REF: begin
          ba_q   <= '0;
          addr_q <= '0;
        end
        default: ;
      endcase

      // ODT rises with the WR on the bus and any later WR restarts the window.
      if (cmd == CMD_WR) begin
        odt_q     <= ODT_ON;
        odt_cnt_q <= ODT_W'(ODT_LOAD);
      end else if (odt_cnt_q != '0) begin
        odt_q     <= 1'b1;
        odt_cnt_q <= odt_cnt_q - 1'b1;
      end else begin
        odt_q <= 1'b0;
      end
    end
  end

  assign dfi_cke   = cke_q;
  assign dfi_cs_n  = cs_n_q;
  assign dfi_ras_n = cmd_q[2];
  assign dfi_cas_n = cmd_q[1];
  assign dfi_we_n  = cmd_q[0];
  assign dfi_ba    = ba_q;
  assign dfi_addr  = addr_q;
  assign dfi_odt   = odt_q;

endmodule

// File: tb/tb_dfi_cmd_sched.sv
// Directed bench for dfi_cmd_sched: spacing, priority, round-robin, ODT window
// and mid-run reset, with hand-computed expectations.
module tb_dfi_cmd_sched;

  localparam int NB = 8;
  localparam int AW = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [NB-1:0]    act_req, rd_req, wr_req, pre_req;
  logic             ref_req;
  logic [NB*AW-1:0] bk_addr;
  logic [NB-1:0]    act_gnt, rd_gnt, wr_gnt, pre_gnt;
  logic             ref_gnt;
  logic [3:0]       t_rrd, t_ccd, t_wtr, t_rtw;
  logic             dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt;
  logic [0:0]       dfi_cs_n;
  logic [2:0]       dfi_ba;
  logic [AW-1:0]    dfi_addr;

  int checks = 0;
  int errors = 0;

  dfi_cmd_sched dut (
    .clk(clk), .rst(rst),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req),
    .ref_req(ref_req), .bk_addr(bk_addr),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt),
    .ref_gnt(ref_gnt),
    .t_rrd(t_rrd), .t_ccd(t_ccd), .t_wtr(t_wtr), .t_rtw(t_rtw),
    .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n),
    .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba),
    .dfi_addr(dfi_addr), .dfi_odt(dfi_odt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dfi(input string tag, input logic [2:0] cmd, input logic cs_n,
                           input logic [2:0] ba, input logic [AW-1:0] addr);
    check({tag, "_cs_n"}, dfi_cs_n, cs_n);
    check({tag, "_cmd"}, {dfi_ras_n, dfi_cas_n, dfi_we_n}, cmd);
    check({tag, "_ba"}, dfi_ba, ba);
    check({tag, "_addr"}, dfi_addr, addr);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] baddr(input int b);
    return AW'(16'h0200 + b);
  endfunction

  // Illegal stimulus guard and per-cycle grant sanity.
  always @(posedge clk)
    if (!rst) assert (!(|(rd_req & wr_req))) else $error("rd_req and wr_req on one bank");

  always @(negedge clk) begin
    check("gnt_onehot", 64'($countones({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}) <= 1), 1);
    check("gnt_needs_req", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}
                           & ~{act_req, rd_req, wr_req, pre_req, ref_req}, 0);
  end

  initial begin
    rst = 1'b1;
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = 1'b0;
    t_rrd = 4'd4; t_ccd = 4'd1; t_wtr = 4'd1; t_rtw = 4'd1;
    for (int i = 0; i < NB; i++) bk_addr[i*AW +: AW] = baddr(i);

    // Reset values, grants forced low even with requests pending.
    repeat (3) cycle();
    act_req = 8'hFF;
    #1;
    check("rst_act_gnt", act_gnt, 0);
    check("rst_cke", dfi_cke, 0);
    check("rst_odt", dfi_odt, 0);
    check_dfi("rst", 3'b111, 1'b1, 3'd0, '0);

    // ACT round robin with t_rrd=4: banks 0,1,2,3 at cycles 0,4,8,12.
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 13; c++) begin
      #1;
      check("act_gnt", act_gnt, (c % 4 == 0) ? 64'(1 << (c / 4)) : 64'd0);
      cycle();
      if (c == 0) check("cke_up", dfi_cke, 1);
      if (c % 4 == 0) check_dfi("act", 3'b011, 1'b0, 3'(c / 4), baddr(c / 4));
      else            check_dfi("act_hold", 3'b111, 1'b1, 3'(c / 4), baddr(c / 4));
    end
    act_req = '0;

    // WR bank 2 then RD bank 2, t_wtr=5: RD five cycles after WR; ODT four cycles.
    t_wtr = 4'd5; t_ccd = 4'd2;
    wr_req = 8'h04;
    #1;
    check("wr_gnt", wr_gnt, 8'h04);
    cycle();
    wr_req = '0;
    rd_req = 8'h04;
    check_dfi("wr", 3'b100, 1'b0, 3'd2, baddr(2));
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("wtr_rd_gnt", rd_gnt, (k == 5) ? 64'h04 : 64'h0);
      check("odt_window", dfi_odt, (k <= 4) ? 64'd1 : 64'd0);
      cycle();
    end
    rd_req = '0;
    check_dfi("rd", 3'b101, 1'b0, 3'd2, baddr(2));
    check("odt_off", dfi_odt, 0);
    repeat (4) cycle();

    // REF beats ACT when counters are idle.
    ref_req = 1'b1;
    act_req = 8'h01;
    #1;
    check("ref_gnt", ref_gnt, 1);
    check("ref_act_gnt", act_gnt, 0);
    cycle();
    ref_req = 1'b0;
    check_dfi("ref", 3'b001, 1'b0, 3'd0, '0);
    #1;
    check("act_after_ref", act_gnt, 8'h01);
    cycle();
    act_req = '0;
    ref_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("ref_wait_rrd", ref_gnt, (k == 4) ? 64'd1 : 64'd0);
      cycle();
    end
    ref_req = 1'b0;
    check_dfi("ref2", 3'b001, 1'b0, 3'd0, '0);

    // RD beats PRE; PRE follows with address forced to 0.
    rd_req = 8'h02;
    pre_req = 8'h20;
    #1;
    check("cas_over_pre_rd", rd_gnt, 8'h02);
    check("cas_over_pre_pre", pre_gnt, 0);
    cycle();
    rd_req = '0;
    #1;
    check("pre_gnt", pre_gnt, 8'h20);
    check_dfi("rd_b1", 3'b101, 1'b0, 3'd1, baddr(1));
    cycle();
    pre_req = '0;
    check_dfi("pre", 3'b010, 1'b0, 3'd5, '0);
    cycle();

    // Mid-run reset with rtw pending and ODT active.
    t_wtr = 4'd1; t_ccd = 4'd1; t_rtw = 4'd4;
    wr_req = 8'h08;
    cycle();
    wr_req = '0;
    rd_req = 8'h08;
    #1;
    check("rd_b3_gnt", rd_gnt, 8'h08);
    cycle();
    rd_req = '0;
    check("odt_before_rst", dfi_odt, 1);
    rst = 1'b1;
    wr_req = 8'h08;
    #1;
    check("rst_wr_gnt", wr_gnt, 0);
    cycle();
    check("rst2_cke", dfi_cke, 0);
    check("rst2_odt", dfi_odt, 0);
    check_dfi("rst2", 3'b111, 1'b1, 3'd0, '0);
    rst = 1'b0;
    #1;
    check("wr_after_rst", wr_gnt, 8'h08);
    cycle();
    wr_req = '0;
    check_dfi("wr_after_rst", 3'b100, 1'b0, 3'd3, baddr(3));
    check("odt_after_rst", dfi_odt, 1);

    // Back-to-back RD with t_ccd=0 then t_ccd=1, alternating banks 4 and 0.
    t_ccd = 4'd0;
    rd_req = 8'h11;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) t_ccd = 4'd1;
      #1;
      check("b2b_rd_gnt", rd_gnt, (k % 2 == 0) ? 64'h10 : 64'h01);
      cycle();
      check_dfi("b2b_rd", 3'b101, 1'b0, (k % 2 == 0) ? 3'd4 : 3'd0,
                baddr((k % 2 == 0) ? 4 : 0));
    end
    rd_req = '0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
